bus_cycle_controller: RTL

BUS_CYCLE_CONTROLLER -- requirements
Module: bus_cycle_controller

---
 rtl/bus_cycle_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bus_cycle_controller.sv
// 68000-style bus cycle controller: per-region wait states, DRAM ready handshake, DTACK/BERR strobes.
// Define BUS_TIMEOUT_EN to build the WAIT-state timeout counter and the BERR path.
module bus_cycle_controller #(
  parameter int ROM_WAIT       = 0,
  parameter int RAM_WAIT       = 1,
  parameter int IO_WAIT        = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic Clock,
  input  logic Reset_H,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic IOSelect_H,
  input  logic DramSelect_H,
  input  logic DramReady_H,
  output logic DTACK_L,
  output logic BERR_L,
  output logic Busy_H
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BERR} state_e;
  typedef enum logic [2:0] {R_ROM, R_RAM, R_IO, R_DRAM, R_NONE} region_e;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  state_e      state_q, state_d;
  region_e     region_q, region_d, sel_region;
  logic [7:0]  wait_q, wait_d, sel_wait;
  logic        dtack_q, dtack_d;
  logic        done;
  logic        tmo_hit;

  // Decoder selects may overlap; fixed priority ROM > RAM > IO > DRAM.
  always_comb begin
    sel_region = R_NONE;
    sel_wait   = '0;
    if (OnChipRomSelect_H) begin
      sel_region = R_ROM;
      sel_wait   = 8'(ROM_WAIT);
    end else if (OnChipRamSelect_H) begin
      sel_region = R_RAM;
      sel_wait   = 8'(RAM_WAIT);
    end else if (IOSelect_H) begin
      sel_region = R_IO;
      sel_wait   = 8'(IO_WAIT);
    end else if (DramSelect_H) begin
      sel_region = R_DRAM;
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       berr_q, berr_d;

  assign tmo_hit = (tmo_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_IDLE)
      tmo_d = '0;
    else if (state_q == S_WAIT && tmo_q != 8'hFF)
      tmo_d = tmo_q + 8'd1;
  end

  always_ff @(posedge Clock) begin
    if (Reset_H) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    wait_d   = wait_q;
    dtack_d  = dtack_q;
`ifdef BUS_TIMEOUT_EN
    berr_d   = berr_q;
`endif
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!AS_L && (!UDS_L || !LDS_L)) begin
          state_d  = S_WAIT;
          region_d = sel_region;
          wait_d   = sel_wait;
        end
      end
      S_WAIT: begin
        unique case (region_q)
          R_ROM, R_RAM, R_IO: done = (wait_q == '0);
          R_DRAM:             done = DramReady_H;
          default:            done = 1'b0;
        endcase
        if (wait_q != '0) wait_d = wait_q - 8'd1;
        // Abort beats completion, completion beats timeout.
        if (AS_L) begin
          state_d = S_IDLE;
        end else if (done) begin
          state_d = S_ACK;
          dtack_d = 1'b0;
        end else if (tmo_hit) begin
          state_d = S_BERR;
`ifdef BUS_TIMEOUT_EN
          berr_d  = 1'b0;
`endif
        end
      end
      S_ACK, S_BERR: begin
        if (AS_L) begin
          state_d = S_IDLE;
          dtack_d = 1'b1;
`ifdef BUS_TIMEOUT_EN
          berr_d  = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state_q  <= S_IDLE;
      region_q <= R_NONE;
      wait_q   <= '0;
      dtack_q  <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      berr_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      wait_q   <= wait_d;
      dtack_q  <= dtack_d;
`ifdef BUS_TIMEOUT_EN
      berr_q   <= berr_d;
`endif
    end
  end

  assign DTACK_L = dtack_q;
`ifdef BUS_TIMEOUT_EN
  assign BERR_L  = berr_q;
`else
  assign BERR_L  = 1'b1;
`endif
  assign Busy_H  = (state_q != S_IDLE);

endmodule
